alu_link_host: RTL and testbench
================================

Name: alu_link_host

Overview:
Host-side initiator for the UART ALU echo link. It sends one operand byte to the far-end ALU responder and collects the two-byte reply: the result byte first, then the flags byte. It checks the reply against a locally computed Z80 8-bit ADD, and it reports the outcome on a valid/ready response port. It sits between a request source and byte-level uart_tx/uart_rx instances, which are external to this block.

Parameters:
ADD_CONST, 8'd42, constant the responder adds to the operand; used to compute the expected reply.
TIMEOUT_CLKS, 50000, clk cycles allowed from tx_start to the flags byte; must be >= 2.

Ports:
clk  input  1  system clock (12 MHz)
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  operand request valid
req_ready  output  1  high only in IDLE
req_operand  input  8  operand byte to send
tx_start  output  1  one-cycle pulse to uart_tx
tx_data  output  8  byte to uart_tx; holds the operand
tx_busy  input  1  uart_tx busy
rx_data  input  8  byte from uart_rx; valid while rx_ready is high
rx_ready  input  1  one-cycle strobe from uart_rx
rsp_valid  output  1  response valid; held until accepted
rsp_ready  input  1  response accepted
rsp_result  output  8  received result byte
rsp_flags  output  8  received flags byte {S,Z,0,H,0,PV,N,C}
rsp_timeout  output  1  reply incomplete
rsp_mismatch  output  1  received bytes differ from expected
stray_cnt  output  8  saturating count of unexpected rx bytes

Behaviour:
- Reset, asynchronous, while rst_n=0:
  - all outputs are 0 except req_ready=1; state is IDLE.
  - the timeout counter is cleared; stray_cnt=0.
  - Reset mid-transaction abandons it and emits no response.
- IDLE:
  - req_ready=1.
  - On req_valid, latch req_operand into tx_data and compute the expected result/flags, then go to TX_ISSUE. req_ready drops the next cycle.
- TX_ISSUE:
  - Wait while tx_busy=1.
  - On the first cycle with tx_busy=0, pulse tx_start high for exactly one cycle, clear the timeout counter and go to RX_RES.
- RX_RES:
  - On rx_ready, capture rx_data into rsp_result and go to RX_FLG.
- RX_FLG:
  - On rx_ready, capture rx_data into rsp_flags and go to RESP with rsp_timeout=0.
- Timeout:
  - The counter increments every cycle in RX_RES and RX_FLG.
  - When the count reaches TIMEOUT_CLKS-1 without the awaited byte, go to RESP with rsp_timeout=1. Bytes not yet received read as 0x00.
  - If rx_ready arrives in that same cycle, the byte is captured and the timeout does not fire (the byte wins).
- RESP:
  - rsp_valid=1; all rsp_* outputs are stable.
  - On rsp_ready, go to IDLE; rsp_valid=0 the next cycle.
  - rsp_valid may be high in the same cycle as rsp_ready; there is no combinational path from rsp_ready to rsp_valid.
- Expected value computation:
  - sum = (operand + ADD_CONST) mod 256.
  - C = carry out of bit 7.
  - H = carry out of bit 3.
  - PV = signed overflow (operands have the same sign and the sum's sign differs).
  - Z = (sum == 0).
  - S = sum[7].
  - N = 0; bits 5 and 3 are 0.
- rsp_mismatch:
  - 1 if the result or the flags byte differs from expected.
  - Forced to 0 when rsp_timeout=1.
- stray_cnt:
  - An rx_ready in IDLE, TX_ISSUE or RESP is stray; the byte is discarded and stray_cnt increments, saturating at 255.
  - Stray bytes never alter rsp_* fields.
- tx_data is held constant from TX_ISSUE until the next request is latched.
- Latency: from tx_start to rsp_valid is 1 cycle after the flags byte's rx_ready.

Test Plan:
- req_operand=0x10, responder returns 0x3A then 0x00 -> exactly one tx_start with tx_data=0x10; rsp_valid with result 0x3A, flags 0x00, timeout=0, mismatch=0.
- req_operand=0xD6, responder returns 0x00 then 0x51 -> rsp_result=0x00, rsp_flags=0x51, mismatch=0. req_operand=0x60 with reply 0x8A then 0x84 -> mismatch=0.
- req_operand=0x10, responder returns 0x3B then 0x00 -> mismatch=1. Hold rsp_ready=0 for 20 cycles -> rsp_valid and the fields stay stable; req_ready stays 0.
- TIMEOUT_CLKS=100, only the result byte 0x3A arrives -> rsp_valid exactly 100 cycles after tx_start with result 0x3A, flags 0x00, timeout=1, mismatch=0.
- tx_busy held high for 500 cycles when the request arrives -> tx_start is delayed until tx_busy falls. Three rx_ready pulses in IDLE -> stray_cnt=3 and the next transaction is unaffected.
- Assert rst_n low while in RX_FLG -> asynchronous clear with no response. After release, the next request completes normally; a second flags byte arriving after reset counts as stray.

Source files
------------

// File: rtl/alu_link_host_if.sv
// Request/response handshake bundle between a request source and alu_link_host.
// Latency: none, wires only.
// Backpressure: req_valid/req_ready on the request side, rsp_valid/rsp_ready on the response side.
interface alu_link_host_if;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_operand;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_result;
    logic [7:0] rsp_flags;
    logic       rsp_timeout;
    logic       rsp_mismatch;

    // Request source / response consumer side.
    modport master (
        output req_valid, req_operand, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_flags, rsp_timeout, rsp_mismatch
    );

    // Link host side.
    modport slave (
        input  req_valid, req_operand, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_flags, rsp_timeout, rsp_mismatch
    );
endinterface

// File: rtl/alu_link_host.sv
// Host initiator for the UART ALU echo link: send one operand, collect result+flags, check vs Z80 ADD.
// Latency: rsp_valid one cycle after the flags byte strobe, or TIMEOUT_CLKS cycles after tx_start.
// Backpressure: accepts a request only in IDLE; holds the response until rsp_ready.
module alu_link_host #(
    parameter logic [7:0] ADD_CONST    = 8'd42,
    parameter int         TIMEOUT_CLKS = 50000
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_link_host_if.slave     bus,
    output logic               tx_start,
    output logic [7:0]         tx_data,
    input  logic               tx_busy,
    input  logic [7:0]         rx_data,
    input  logic               rx_ready,
    output logic [7:0]         stray_cnt
);

    localparam int CW = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CLKS - 1);

    typedef enum logic [2:0] {
        IDLE,
        TX_ISSUE,
        RX_RES,
        RX_FLG,
        RESP
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [7:0]    exp_res;
    logic [7:0]    exp_flg;
    logic          req_ready_q;
    logic          rsp_valid_q;
    logic [7:0]    rsp_result_q;
    logic [7:0]    rsp_flags_q;
    logic          rsp_timeout_q;
    logic          rsp_mismatch_q;

    logic [8:0]    sum9;
    logic [4:0]    nib5;
    logic          ovf;
    logic [7:0]    calc_flg;

    assign bus.req_ready    = req_ready_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_result   = rsp_result_q;
    assign bus.rsp_flags    = rsp_flags_q;
    assign bus.rsp_timeout  = rsp_timeout_q;
    assign bus.rsp_mismatch = rsp_mismatch_q;

    // Expected Z80 ADD result and flags for the operand presented on the request port.
    always_comb begin
        sum9     = {1'b0, bus.req_operand} + {1'b0, ADD_CONST};
        nib5     = {1'b0, bus.req_operand[3:0]} + {1'b0, ADD_CONST[3:0]};
        ovf      = (bus.req_operand[7] == ADD_CONST[7]) && (sum9[7] != bus.req_operand[7]);
        calc_flg = {sum9[7], (sum9[7:0] == 8'h00), 1'b0, nib5[4], 1'b0, ovf, 1'b0, sum9[8]};
    end

    // Transaction FSM with registered outputs, timeout counter and stray-byte counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            exp_res        <= 8'h00;
            exp_flg        <= 8'h00;
            req_ready_q    <= 1'b1;
            tx_start       <= 1'b0;
            tx_data        <= 8'h00;
            rsp_valid_q    <= 1'b0;
            rsp_result_q   <= 8'h00;
            rsp_flags_q    <= 8'h00;
            rsp_timeout_q  <= 1'b0;
            rsp_mismatch_q <= 1'b0;
            stray_cnt      <= 8'h00;
        end else begin
            tx_start <= 1'b0;

            // Bytes outside the receive window are discarded and only counted.
            if (rx_ready && (state == IDLE || state == TX_ISSUE || state == RESP)
                && stray_cnt != 8'hFF) begin
                stray_cnt <= stray_cnt + 8'd1;
            end

            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        tx_data     <= bus.req_operand;
                        exp_res     <= sum9[7:0];
                        exp_flg     <= calc_flg;
                        req_ready_q <= 1'b0;
                        state       <= TX_ISSUE;
                    end
                end
                TX_ISSUE: begin
                    if (!tx_busy) begin
                        tx_start       <= 1'b1;
                        cnt            <= '0;
                        // Fields of the previous response are cleared so missing bytes read as 0.
                        rsp_result_q   <= 8'h00;
                        rsp_flags_q    <= 8'h00;
                        rsp_timeout_q  <= 1'b0;
                        rsp_mismatch_q <= 1'b0;
                        state          <= RX_RES;
                    end
                end
                RX_RES: begin
                    if (rx_ready) begin
                        rsp_result_q <= rx_data;
                        // Counter keeps running across both bytes; it parks at the last value.
                        if (cnt != CNT_LAST) begin
                            cnt <= cnt + 1'b1;
                        end
                        state <= RX_FLG;
                    end else if (cnt == CNT_LAST) begin
                        rsp_timeout_q <= 1'b1;
                        rsp_valid_q   <= 1'b1;
                        state         <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_FLG: begin
                    if (rx_ready) begin
                        rsp_flags_q    <= rx_data;
                        rsp_mismatch_q <= (rsp_result_q != exp_res) || (rx_data != exp_flg);
                        rsp_valid_q    <= 1'b1;
                        state          <= RESP;
                    end else if (cnt == CNT_LAST) begin
                        rsp_timeout_q <= 1'b1;
                        rsp_valid_q   <= 1'b1;
                        state         <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_link_host.sv
// Directed bench for alu_link_host with a queue of expected responses from an arithmetic Z80 ADD model.
// Latency: checks tx_start, flags-to-rsp_valid and timeout distances in cycles.
// Backpressure: holds rsp_ready low for a while and checks the response stays put.
module tb_alu_link_host;

    localparam int TMO = 100;

    typedef struct {
        logic [7:0] res;
        logic [7:0] flg;
        logic       tmo;
        logic       mis;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic [7:0] stray_cnt;

    alu_link_host_if bus ();

    alu_link_host #(.ADD_CONST(8'd42), .TIMEOUT_CLKS(TMO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_busy   (tx_busy),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .stray_cnt (stray_cnt)
    );

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   tx_cnt = 0;
    int   stray_model = 0;
    logic [7:0] exp_op = 8'h00;
    exp_t expq[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Z80 8-bit ADD of operand and 42, written with plain integer arithmetic.
    function automatic logic [15:0] model_add(input int op);
        int s, res, so, ss, f;
        s   = op + 42;
        res = s % 256;
        so  = (op >= 128) ? op - 256 : op;
        ss  = so + 42;
        f   = 0;
        if (res >= 128)                 f += 128;
        if (res == 0)                   f += 64;
        if ((op % 16) + (42 % 16) > 15) f += 16;
        if (ss > 127 || ss < -128)      f += 4;
        if (s > 255)                    f += 1;
        return {8'(res), 8'(f)};
    endfunction

    // Single compare process: every active cycle, DUT outputs against the expectation queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_start) begin
                tx_cnt++;
                check("tx_data at tx_start", 32'(tx_data), 32'(exp_op));
            end
            if (bus.rsp_valid) begin
                if (expq.size() == 0) begin
                    check("rsp_valid without request", 32'(bus.rsp_valid), 32'd0);
                end else begin
                    check("rsp_result", 32'(bus.rsp_result), 32'(expq[0].res));
                    check("rsp_flags", 32'(bus.rsp_flags), 32'(expq[0].flg));
                    check("rsp_timeout", 32'(bus.rsp_timeout), 32'(expq[0].tmo));
                    check("rsp_mismatch", 32'(bus.rsp_mismatch), 32'(expq[0].mis));
                    check("req_ready low in RESP", 32'(bus.req_ready), 32'd0);
                    check("tx_data held", 32'(tx_data), 32'(exp_op));
                    if (bus.rsp_ready) void'(expq.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic stray_byte(input logic [7:0] b);
        rx_ready = 1'b1;
        rx_data  = b;
        tick();
        rx_ready = 1'b0;
        if (stray_model < 255) stray_model++;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_ready = 1'b1;
        rx_data  = b;
        tick();
        rx_ready = 1'b0;
    endtask

    // nbytes: 0/1 = timeout after that many bytes, 2 = normal reply, 3 = flags on the last allowed cycle.
    task automatic do_txn(input logic [7:0] op, input logic [7:0] r0, input logic [7:0] r1,
                          input int nbytes, input int hold, input int busy);
        exp_t e;
        logic [15:0] m;
        int k, t0, txc;
        m = model_add(int'(op));
        e.res = (nbytes >= 1) ? r0 : 8'h00;
        e.flg = (nbytes >= 2) ? r1 : 8'h00;
        e.tmo = (nbytes < 2);
        e.mis = (nbytes >= 2) && ((r0 != m[15:8]) || (r1 != m[7:0]));
        expq.push_back(e);
        exp_op  = op;
        txc     = tx_cnt;
        tx_busy = (busy > 0);
        k = 0;
        while (!bus.req_ready && k < 50) begin tick(); k++; end
        check("req_ready in idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid   = 1'b1;
        bus.req_operand = op;
        tick();
        bus.req_valid = 1'b0;
        check("req_ready drops", 32'(bus.req_ready), 32'd0);
        if (busy > 0) begin
            repeat (busy) tick();
            check("no tx_start while busy", 32'(tx_cnt), 32'(txc));
            tx_busy = 1'b0;
        end
        k = 0;
        while (!tx_start && k < 5) begin tick(); k++; end
        check("tx_start seen", 32'(tx_start), 32'd1);
        t0 = cyc;
        if (nbytes >= 1) begin
            repeat (3) tick();
            send_byte(r0);
        end
        if (nbytes == 2) begin
            repeat (4) tick();
            send_byte(r1);
            check("rsp one cycle after flags", 32'(bus.rsp_valid), 32'd1);
        end else if (nbytes == 3) begin
            while (cyc - t0 < TMO - 1) tick();
            send_byte(r1);
            check("flags on last cycle wins", 32'(bus.rsp_valid), 32'd1);
        end
        k = 0;
        while (!bus.rsp_valid && k < 300) begin tick(); k++; end
        check("rsp_valid seen", 32'(bus.rsp_valid), 32'd1);
        if (nbytes < 2) check("timeout latency", 32'(cyc - t0), 32'(TMO));
        repeat (hold) tick();
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check("rsp_valid drops", 32'(bus.rsp_valid), 32'd0);
        check("req_ready back", 32'(bus.req_ready), 32'd1);
        check("one tx_start", 32'(tx_cnt), 32'(txc + 1));
        check("stray_cnt", 32'(stray_cnt), 32'(stray_model));
        check("response consumed", 32'(expq.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        int k;
        rst_n           = 1'b1;
        tx_busy         = 1'b0;
        rx_data         = 8'h00;
        rx_ready        = 1'b0;
        bus.req_valid   = 1'b0;
        bus.req_operand = 8'h00;
        bus.rsp_ready   = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("reset req_ready", 32'(bus.req_ready), 32'd1);
        check("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset tx_start", 32'(tx_start), 32'd0);
        check("reset tx_data", 32'(tx_data), 32'd0);
        check("reset stray_cnt", 32'(stray_cnt), 32'd0);
        check("reset rsp fields", 32'({bus.rsp_result, bus.rsp_flags, bus.rsp_timeout, bus.rsp_mismatch}), 32'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Pin the model with hand-worked sums.
        check("model 0x10", 32'(model_add(16)), 32'h3A00);
        check("model 0xD6", 32'(model_add(214)), 32'h0051);
        check("model 0x60", 32'(model_add(96)), 32'h8A84);

        do_txn(8'h10, 8'h3A, 8'h00, 2, 0, 0);
        do_txn(8'hD6, 8'h00, 8'h51, 2, 0, 0);
        do_txn(8'h60, 8'h8A, 8'h84, 2, 0, 0);
        do_txn(8'h10, 8'h3B, 8'h00, 2, 20, 0);
        do_txn(8'h10, 8'h3A, 8'h00, 1, 0, 0);
        do_txn(8'h20, 8'h00, 8'h00, 0, 3, 0);
        do_txn(8'hFF, 8'h29, 8'h11, 3, 0, 0);
        do_txn(8'h05, 8'h2F, 8'h00, 2, 0, 500);

        stray_byte(8'hA1);
        stray_byte(8'hA2);
        stray_byte(8'hA3);
        check("three strays", 32'(stray_cnt), 32'd3);
        do_txn(8'h80, 8'hAA, 8'h80, 2, 2, 0);

        // Abort a transaction in RX_FLG with an asynchronous reset.
        exp_op          = 8'h10;
        bus.req_valid   = 1'b1;
        bus.req_operand = 8'h10;
        tick();
        bus.req_valid = 1'b0;
        k = 0;
        while (!tx_start && k < 5) begin tick(); k++; end
        check("abort tx_start seen", 32'(tx_start), 32'd1);
        repeat (2) tick();
        send_byte(8'h3A);
        repeat (2) tick();
        #2 rst_n = 1'b0;
        #1;
        stray_model = 0;
        check("async reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("async reset req_ready", 32'(bus.req_ready), 32'd1);
        check("async reset tx_data", 32'(tx_data), 32'd0);
        check("async reset stray_cnt", 32'(stray_cnt), 32'd0);
        check("async reset rsp_result", 32'(bus.rsp_result), 32'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        check("no response after reset", 32'(bus.rsp_valid), 32'd0);
        stray_byte(8'h00);
        check("late flags is stray", 32'(stray_cnt), 32'd1);
        do_txn(8'h60, 8'h8A, 8'h84, 2, 0, 0);

        repeat (5) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
